// File: rtl/mnd_seq_if.sv
// MND sequencer bus: E-stage command inputs, D-stage hazard query,
// and the busy/stall/HI/LO results returned to the pipeline.
interface mnd_seq_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        cancel;
    logic        d_uses_mnd;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    // Pipeline side: issues commands, observes results
    modport master (
        output start, op, a, b, hi_we, lo_we, wdata, cancel, d_uses_mnd,
        input  busy, stall, hi, lo
    );

    // Sequencer side
    modport slave (
        input  start, op, a, b, hi_we, lo_we, wdata, cancel, d_uses_mnd,
        output busy, stall, hi, lo
    );
endinterface

// File: rtl/mnd_seq.sv
// Multiply/divide sequencer for the E stage. The arithmetic result is
// computed on the accept edge and held in pending registers; HI/LO only
// change once the modelled latency has elapsed, so a reset mid-operation
// leaves no partial write behind.
module mnd_seq #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10,
    parameter int unsigned CNT_W       = 4
) (
    input  logic       clk,
    input  logic       reset,
    mnd_seq_if.slave   m
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic               busy_q;
    logic [31:0]        hi_q;
    logic [31:0]        lo_q;
    logic [31:0]        pend_hi;
    logic [31:0]        pend_lo;

    logic               acc;
    logic               mt;
    logic               commit;

    logic [63:0]        prod;
    logic [31:0]        mag_a;
    logic [31:0]        mag_b;
    logic [31:0]        uq;
    logic [31:0]        ur;
    logic [31:0]        res_hi;
    logic [31:0]        res_lo;

    // Command qualification and next-state selection
    always_comb begin
        acc        = 1'b0;
        mt         = 1'b0;
        commit     = 1'b0;
        state_next = state;
        case (state)
            IDLE: begin
                acc = m.start & ~m.cancel;
                // start wins over a simultaneous MTHI/MTLO
                mt  = (m.hi_we | m.lo_we) & ~m.cancel & ~m.start;
                if (acc) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (cnt == CNT_W'(1)) begin
                    commit     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // 64-bit result of the operation presented this cycle
    always_comb begin
        prod   = '0;
        mag_a  = '0;
        mag_b  = '0;
        uq     = '0;
        ur     = '0;
        res_hi = hi_q;
        res_lo = lo_q;
        case (m.op)
            2'd0: begin
                prod   = {{32{m.a[31]}}, m.a} * {{32{m.b[31]}}, m.b};
                res_hi = prod[63:32];
                res_lo = prod[31:0];
            end
            2'd1: begin
                prod   = {32'd0, m.a} * {32'd0, m.b};
                res_hi = prod[63:32];
                res_lo = prod[31:0];
            end
            2'd2: begin
                // Divide magnitudes, then restore signs; this also yields
                // 0x80000000 / -1 = 0x80000000 rem 0 without overflow.
                if (m.b != '0) begin
                    mag_a  = m.a[31] ? -m.a : m.a;
                    mag_b  = m.b[31] ? -m.b : m.b;
                    uq     = mag_a / mag_b;
                    ur     = mag_a % mag_b;
                    res_lo = (m.a[31] ^ m.b[31]) ? -uq : uq;
                    res_hi = m.a[31] ? -ur : ur;
                end
            end
            default: begin
                if (m.b != '0) begin
                    res_lo = m.a / m.b;
                    res_hi = m.a % m.b;
                end
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Latency counter, busy flag, pending result and HI/LO registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            busy_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
        end else begin
            if (acc) begin
                pend_hi <= res_hi;
                pend_lo <= res_lo;
                cnt     <= (m.op[1] == 1'b0) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                busy_q  <= 1'b1;
            end else if (state == BUSY) begin
                cnt <= cnt - CNT_W'(1);
                if (commit) begin
                    hi_q   <= pend_hi;
                    lo_q   <= pend_lo;
                    busy_q <= 1'b0;
                end
            end else if (mt) begin
                if (m.hi_we) hi_q <= m.wdata;
                if (m.lo_we) lo_q <= m.wdata;
            end
        end
    end

    assign m.busy  = busy_q;
    assign m.stall = m.d_uses_mnd & (busy_q | (m.start & ~m.cancel));
    assign m.hi    = hi_q;
    assign m.lo    = lo_q;

endmodule

// File: tb/tb_mnd_seq.sv
// Directed bench for mnd_seq: expected commits are queued by the stimulus
// and checked by a monitor whenever busy falls.
module tb_mnd_seq;

    logic clk;
    logic reset;

    mnd_seq_if bus ();

    mnd_seq #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10),
        .CNT_W       (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .m     (bus.slave)
    );

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    logic prev_busy = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.start      = 1'b0;
        bus.op         = 2'd0;
        bus.a          = '0;
        bus.b          = '0;
        bus.hi_we      = 1'b0;
        bus.lo_we      = 1'b0;
        bus.wdata      = '0;
        bus.cancel     = 1'b0;
        bus.d_uses_mnd = 1'b0;
    endtask

    // Issue one start for a cycle and queue the expected commit
    task automatic issue(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        exp_q.push_back('{name, eh, el});
        cycle();
        bus.start = 1'b0;
    endtask

    // Count remaining busy cycles (the accept edge already passed)
    task automatic count_busy(input string name, input int req);
        int n;
        n = 0;
        while (bus.busy === 1'b1 && n < 30) begin
            n++;
            cycle();
        end
        chk({name, " busy cycles"}, 32'(n), 32'(req));
    endtask

    // Monitor: a falling busy means a commit; compare against the queue
    always @(negedge clk) begin
        if (reset !== 1'b1) begin
            prev_busy <= 1'b0;
        end else begin
            if (prev_busy === 1'b1 && bus.busy === 1'b0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected commit", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk({e.name, " hi"}, bus.hi, e.hi);
                    chk({e.name, " lo"}, bus.lo, e.lo);
                end
            end
            prev_busy <= bus.busy;
        end
    end

    initial begin
        idle_inputs();
        reset = 1'b0;
        #12;
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset hi", bus.hi, 32'h0);
        chk("reset lo", bus.lo, 32'h0);
        chk("reset stall", 32'(bus.stall), 32'd0);
        cycle();
        reset = 1'b1;
        cycle();

        // MULT -2 * 3, with D using the MND
        bus.d_uses_mnd = 1'b1;
        bus.start = 1'b1;
        bus.op    = 2'd0;
        #1;
        chk("stall on start cycle", 32'(bus.stall), 32'd1);
        bus.start = 1'b0;
        issue("mult -2*3", 2'd0, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        chk("stall during busy", 32'(bus.stall), 32'd1);
        count_busy("mult", 5);
        chk("stall after busy", 32'(bus.stall), 32'd0);
        bus.d_uses_mnd = 1'b0;
        cycle();

        issue("divu 100/7", 2'd3, 32'd100, 32'd7, 32'd2, 32'd14);
        count_busy("divu", 10);
        cycle();

        issue("div -7/2", 2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        count_busy("div neg", 10);
        cycle();

        issue("div min/-1", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
        count_busy("div ovf", 10);
        cycle();

        // MTHI / MTLO then divide by zero keeps them
        bus.hi_we = 1'b1; bus.wdata = 32'h1234;
        cycle();
        bus.hi_we = 1'b0;
        chk("mthi hi", bus.hi, 32'h1234);
        bus.lo_we = 1'b1; bus.wdata = 32'h5678;
        cycle();
        bus.lo_we = 1'b0;
        chk("mtlo lo", bus.lo, 32'h5678);
        chk("mtlo busy", 32'(bus.busy), 32'd0);
        issue("div by zero", 2'd2, 32'd5, 32'd0, 32'h1234, 32'h5678);
        count_busy("div0", 10);
        cycle();

        // Cancelled start and cancelled MTHI
        bus.start = 1'b1; bus.op = 2'd0; bus.a = 32'd3; bus.b = 32'd3;
        bus.cancel = 1'b1; bus.d_uses_mnd = 1'b1;
        #1;
        chk("cancel stall", 32'(bus.stall), 32'd0);
        cycle();
        bus.start = 1'b0; bus.d_uses_mnd = 1'b0;
        chk("cancel busy", 32'(bus.busy), 32'd0);
        chk("cancel hi", bus.hi, 32'h1234);
        chk("cancel lo", bus.lo, 32'h5678);
        bus.hi_we = 1'b1; bus.wdata = 32'hFFFF;
        cycle();
        bus.hi_we = 1'b0; bus.cancel = 1'b0;
        chk("cancel mthi", bus.hi, 32'h1234);
        bus.lo_we = 1'b1; bus.wdata = 32'hCAFE_BABE;
        cycle();
        bus.lo_we = 1'b0;
        chk("mtlo cafebabe", bus.lo, 32'hCAFE_BABE);
        chk("mtlo cafebabe busy", 32'(bus.busy), 32'd0);

        // Start and MTHI while busy are ignored
        issue("mult 7*-3", 2'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        bus.start = 1'b1; bus.op = 2'd3; bus.a = 32'd9; bus.b = 32'd3;
        bus.hi_we = 1'b1; bus.wdata = 32'hDEAD;
        cycle();
        cycle();
        idle_inputs();
        count_busy("mult ignore", 3);
        cycle();
        chk("no restart busy", 32'(bus.busy), 32'd0);

        // Reset in the middle of a DIV aborts it
        bus.start = 1'b1; bus.op = 2'd3; bus.a = 32'd1000; bus.b = 32'd10;
        cycle();
        bus.start = 1'b0;
        cycle();
        cycle();
        reset = 1'b0;
        #1;
        chk("async reset busy", 32'(bus.busy), 32'd0);
        chk("async reset hi", bus.hi, 32'h0);
        chk("async reset lo", bus.lo, 32'h0);
        cycle();
        reset = 1'b1;
        cycle();

        issue("multu ffffffff*2", 2'd1, 32'hFFFF_FFFF, 32'd2, 32'h1, 32'hFFFF_FFFE);
        count_busy("multu", 5);
        cycle();
        cycle();
        chk("scoreboard drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/mnd_seq.md
Name: mnd_seq

Overview:
- Sequencer for the multiply/divide unit (MND) in the E stage of the pipelined MIPS core.
- Accepts MND start/write commands carried by the D/E pipeline register.
- Holds the multi-cycle busy interval and commits results to HI/LO.
- Produces the stall request that the hazard unit ORs into Froze.
- Honours interrupt/exception cancellation, so a cancelled instruction never starts or writes.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU
- DIV_CYCLES, 10, busy cycles for DIV/DIVU
- CNT_W, 4, counter width; must hold max(MULT_CYCLES, DIV_CYCLES)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  E-stage MND instruction starts an operation this cycle
- op  input  2  0=MULT, 1=MULTU, 2=DIV, 3=DIVU
- a  input  32  rs operand (forwarded)
- b  input  32  rt operand (forwarded)
- hi_we  input  1  MTHI in E stage
- lo_we  input  1  MTLO in E stage
- wdata  input  32  MTHI/MTLO data
- cancel  input  1  interrupt/exception taken this cycle; kills start/hi_we/lo_we
- d_uses_mnd  input  1  instruction in D is MULT*/DIV*/MFHI/MFLO/MTHI/MTLO
- busy  output  1  operation in flight
- stall  output  1  stall request for D (combinational)
- hi  output  32  HI register
- lo  output  32  LO register

Behaviour:
- Reset (async, reset==0): state=IDLE, counter=0, busy=0, hi=0, lo=0, pending regs=0. Reset mid-operation aborts; no HI/LO write.
- Effective command: acc = start & ~cancel & (state==IDLE); mt = (hi_we|lo_we) & ~cancel & (state==IDLE).
- States:
  - IDLE --acc--> BUSY.
  - BUSY --(counter==1)--> IDLE.
  - No other transitions.
- On acc edge:
  - Compute the 64-bit result into pending_hi/pending_lo.
  - Load counter = MULT_CYCLES for op<2, otherwise DIV_CYCLES.
- In BUSY: counter decrements each edge. On the edge where counter==1: hi<=pending_hi, lo<=pending_lo, state<=IDLE, busy<=0.
- Timing:
  - busy is registered and is 1 for exactly N cycles after the accept edge.
  - HI/LO show the new value in the first cycle after busy falls.
- Arithmetic:
  - MULT: signed 32x32 -> 64; hi = [63:32], lo = [31:0].
  - MULTU: unsigned 32x32 -> 64; same split.
  - DIV: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend. 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
  - DIVU: unsigned quotient/remainder.
  - Divide by zero (b==0): timing unchanged; at commit hi/lo keep their pre-operation values.
- MTHI/MTLO: with mt set, the next edge writes hi/lo from wdata. This is a single cycle, state stays IDLE, busy stays 0. hi_we and lo_we together write both.
- start and hi_we in the same cycle never occurs (decoder-exclusive). If it does, start wins and the MT write is dropped.
- start or hi_we/lo_we while BUSY: ignored; the in-flight operation is unaffected. The pipeline prevents this through stall.
- cancel: suppresses acc and mt for that cycle only. It does not abort an operation already in BUSY; that instruction has retired past the cancel point.
- stall = d_uses_mnd & (busy | (start & ~cancel)). Combinational; no dependence on the counter value.
- Counter never underflows; it holds 0 in IDLE.

Test Plan:
- MULT a=0xFFFFFFFE (-2), b=3, start 1 cycle -> busy=1 for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA; stall high while d_uses_mnd=1 during busy and the start cycle.
- DIVU a=100, b=7 -> busy 10 cycles; then lo=14, hi=2. DIV a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0. DIV with b=0 after MTHI 0x1234 / MTLO 0x5678 -> busy 10 cycles, then hi=0x1234, lo=0x5678.
- start with cancel=1 -> busy stays 0, stall=0, hi/lo unchanged. hi_we with cancel=1 -> hi unchanged. MTLO 0xCAFEBABE without cancel -> lo=0xCAFEBABE next cycle, busy=0.
- During BUSY of a MULT: assert start (DIVU 9/3) and hi_we with wdata=0xDEAD -> both ignored; the MULT result commits after 5 cycles.
- Pull reset low at cycle 3 of a DIV -> busy=0, hi=lo=0 immediately (async). After release, a new MULTU 0xFFFFFFFF*2 gives hi=1, lo=0xFFFFFFFE.
